// File: rtl/aes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES-128 constants, FSM encoding, S-box, xtime and rcon.
// Revision: 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NB = 4;
    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_fsm_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return c_SBOX[idx +: 8];
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] v;
        case (rnd)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_enc_round.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : aes_enc_round
// Brief   : One combinational AES encryption round:
//           SubBytes -> ShiftRows -> MixColumns (optional) -> AddRoundKey.
// Revision: 1.0  initial release
// ============================================================================
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    input  logic         i_skip_mix,
    output logic [127:0] o_state
);

    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;

    // Byte k = 4*col + row sits at bits [127-8k -: 8].
    for (genvar k = 0; k < 16; k++) begin : g_sub
        assign w_sb[127-8*k -: 8] = sbox(i_state[127-8*k -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;

        // Row r rotates left by r columns.
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
        end

        assign w_a0 = w_sr[127-32*c -: 8];
        assign w_a1 = w_sr[119-32*c -: 8];
        assign w_a2 = w_sr[111-32*c -: 8];
        assign w_a3 = w_sr[103-32*c -: 8];

        assign w_mc[127-32*c -: 32] = {
            xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
            w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
            w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
            xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
        };
    end

    assign o_state = (i_skip_mix ? w_sr : w_mc) ^ i_rkey;

endmodule
`default_nettype wire

// File: rtl/aes_encrypt_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : aes_encrypt_iter
// Brief   : Iterative AES-128 encryptor, one round per clock, round keys
//           expanded on the fly, valid/ready on input and output.
// Revision: 1.0  initial release
// ============================================================================
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int Nr = AES_NR,
    parameter int Nk = AES_NK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [N-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic         busy
);

    localparam logic [3:0] c_LAST_ROUND = 4'(Nr);

    aes_fsm_e     r_fsm;
    aes_fsm_e     w_fsm_nxt;
    logic [3:0]   r_round;
    logic [127:0] r_state;
    logic [N-1:0] r_key;
    logic         w_accept;
    logic [127:0] w_round_out;
    logic [N-1:0] w_key_nxt;
    logic [31:0]  w_sub_rot;
    logic [31:0]  w_kw [Nk];
    logic [31:0]  w_nw [Nk];

    // KeyStep: RotWord, SubWord and rcon on the last word, then a running XOR.
    assign w_sub_rot = {sbox(w_kw[Nk-1][23:16]), sbox(w_kw[Nk-1][15:8]),
                        sbox(w_kw[Nk-1][7:0]),   sbox(w_kw[Nk-1][31:24])}
                     ^ {rcon(r_round), 24'h000000};

    for (genvar i = 0; i < Nk; i++) begin : g_keyword
        assign w_kw[i] = r_key[N-1-32*i -: 32];
        if (i == 0) begin : g_first
            assign w_nw[i] = w_kw[i] ^ w_sub_rot;
        end else begin : g_rest
            assign w_nw[i] = w_nw[i-1] ^ w_kw[i];
        end
        assign w_key_nxt[N-1-32*i -: 32] = w_nw[i];
    end

    aes_enc_round u_round (
        .i_state    (r_state),
        .i_rkey     (w_key_nxt),
        .i_skip_mix (r_round == c_LAST_ROUND),
        .o_state    (w_round_out)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out       = '0;
        w_accept  = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) w_fsm_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                busy = 1'b1;
                if (r_round == c_LAST_ROUND) w_fsm_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out       = r_state;
                if (out_ready) w_fsm_nxt = ST_IDLE;
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch whitened block at acceptance, then one round per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_round <= 4'd0;
        end else begin
            if (w_accept) begin
                r_state <= in ^ key;
                r_key   <= key;
                r_round <= 4'd1;
            end else if (r_fsm == ST_ROUND) begin
                r_state <= w_round_out;
                r_key   <= w_key_nxt;
                r_round <= (r_round == c_LAST_ROUND) ? 4'd0 : r_round + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_aes_encrypt_iter
// Brief   : Directed-vector bench for aes_encrypt_iter (FIPS-197 vectors,
//           backpressure, input churn, asynchronous reset mid-block).
// Revision: 1.0  initial release
// ============================================================================
module tb_aes_encrypt_iter;

    localparam logic [127:0] c_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] pt        = '0;
    logic [127:0] k         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] ct;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_encrypt_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (pt),
        .key       (k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (ct),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one block, wait for the result, then release it.
    task automatic encrypt(input string tag, input logic [127:0] p, input logic [127:0] kk,
                           input logic [127:0] exp, input logic chk_rk,
                           input logic [127:0] exp_rk, input logic churn);
        int cyc;
        cyc = 0;
        pt = p;
        k = kk;
        in_valid = 1'b1;
        chk({tag, " in_ready pre"}, 128'(in_ready), 128'd1);
        tick();
        in_valid = churn;
        out_ready = churn;
        chk({tag, " busy"}, 128'(busy), 128'd1);
        chk({tag, " in_ready busy"}, 128'(in_ready), 128'd0);
        while (!out_valid && cyc < 40) begin
            if (churn) begin
                pt = rnd128();
                k = rnd128();
            end
            tick();
            cyc++;
            if (chk_rk && cyc == 1) chk({tag, " round1 key"}, dut.r_key, exp_rk);
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 128'(cyc), 128'd10);
        chk({tag, " ciphertext"}, ct, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " idle in_ready"}, 128'(in_ready), 128'd1);
        chk({tag, " idle out_valid"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        int cyc;
        logic seen;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 128'(out_valid), 128'd0);
        chk("rst out", ct, 128'd0);
        chk("rst busy", 128'(busy), 128'd0);
        chk("rst in_ready", 128'(in_ready), 128'd1);
        rst = 1'b0;
        tick();
        chk("post-rst in_ready", 128'(in_ready), 128'd1);

        // Known-answer vectors.
        encrypt("C1", c_C1_PT, c_C1_KEY, c_C1_CT, 1'b0, '0, 1'b0);
        encrypt("AppB", c_B_PT, c_B_KEY, c_B_CT, 1'b1, c_B_RK1, 1'b0);
        encrypt("zero", 128'd0, 128'd0, c_Z_CT, 1'b0, '0, 1'b0);

        // Input churn during the rounds; in_valid/out_ready asserted while busy.
        encrypt("churn", c_B_PT, c_B_KEY, c_B_CT, 1'b0, '0, 1'b1);

        // Backpressure: hold the result for 20 cycles while pulsing in_valid.
        pt = c_C1_PT;
        k = c_C1_KEY;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("bp latency", 128'(cyc), 128'd10);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            pt = rnd128();
            k = rnd128();
            tick();
            chk("bp out stable", ct, c_C1_CT);
            chk("bp out_valid", 128'(out_valid), 128'd1);
            chk("bp in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp release in_ready", 128'(in_ready), 128'd1);
        chk("bp release out_valid", 128'(out_valid), 128'd0);

        // Asynchronous reset at round 5, between clock edges.
        pt = c_C1_PT;
        k = c_C1_KEY;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("pre-arst busy", 128'(busy), 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", 128'(out_valid), 128'd0);
        chk("arst in_ready", 128'(in_ready), 128'd1);
        chk("arst busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("arst no output", 128'(seen), 128'd0);
        encrypt("C1 after rst", c_C1_PT, c_C1_KEY, c_C1_CT, 1'b0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
